vend_payout_sequencer: RTL and testbench

- Sequences the physical payout after a sale: first ejects change one coin at a time from the nickel and dime hoppers, then runs the item-release motor.
- Sits between the vending FSM's dispense/refund decode and the actuator drivers.
- Tracks hopper inventory and reports coin jams, item jams and shortage of change.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_timer.sv | 36 +++
 rtl/vend_payout_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_vend_payout_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the payout sequencer: states, fault codes, coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_EJECT,
        ST_WAIT_SENSE,
        ST_GAP,
        ST_MOTOR,
        ST_FAULT
    } state_e;

    localparam logic [1:0] FC_BAD_REQ   = 2'b00;
    localparam logic [1:0] FC_NO_CHANGE = 2'b01;
    localparam logic [1:0] FC_COIN_JAM  = 2'b10;
    localparam logic [1:0] FC_ITEM_JAM  = 2'b11;

    localparam logic [2:0] NICKEL           = 3'd1;
    localparam logic [2:0] DIME             = 3'd2;
    localparam logic [2:0] MAX_CHANGE_UNITS = 3'd4;

    function automatic logic [2:0] coin_units(input logic is_dime);
        return is_dime ? DIME : NICKEL;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; expired_o is high once the count has run down to zero.
module vend_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/vend_payout_sequencer.sv
// Payout sequencer: ejects change one coin at a time (dimes first), then runs the item motor.
module vend_payout_sequencer
    import vend_pkg::*;
#(
    parameter int PULSE_CYC     = 4,
    parameter int GAP_CYC       = 8,
    parameter int SENSE_TIMEOUT = 64,
    parameter int MOTOR_TIMEOUT = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       change_units,
    input  logic             coin_sensed,
    input  logic             item_sensed,
    input  logic             inv_load,
    input  logic [CNT_W-1:0] inv_nickels,
    input  logic [CNT_W-1:0] inv_dimes,
    input  logic             clear_fault,
    output logic             eject5,
    output logic             eject10,
    output logic             motor_on,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt
);

    localparam int TMR_W = $clog2(MOTOR_TIMEOUT + SENSE_TIMEOUT + PULSE_CYC + GAP_CYC);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] SENSE_LD = TMR_W'(SENSE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] MOTOR_LD = TMR_W'(MOTOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    state_e           state_q;
    logic [2:0]       remaining_q;
    logic             coin_dime_q;
    logic             sensed_q;
    logic             eject5_q, eject10_q, motor_q, busy_q, done_q, fault_q;
    logic [1:0]       fault_code_q;
    logic [CNT_W-1:0] nickel_cnt_q, dime_cnt_q;

    logic             pick_dime, pick_nickel;
    logic             enter_eject, enter_gap, enter_motor;
    logic             ph_load, wd_load, ph_exp, wd_exp;
    logic [TMR_W-1:0] ph_val, wd_val;

    assign pick_dime   = (remaining_q >= DIME) && (dime_cnt_q != '0);
    assign pick_nickel = (nickel_cnt_q != '0);
    assign enter_eject = (state_q == ST_PICK) && (remaining_q != 3'd0) && (pick_dime || pick_nickel);
    assign enter_gap   = ((state_q == ST_EJECT) && ph_exp && (sensed_q || coin_sensed)) ||
                         ((state_q == ST_WAIT_SENSE) && coin_sensed);
    assign enter_motor = ((state_q == ST_IDLE) && start && (change_units == 3'd0)) ||
                         ((state_q == ST_PICK) && (remaining_q == 3'd0));

    // Phase timer paces pulse/gap; watchdog covers sense and motor timeouts, both from state entry.
    assign ph_load = enter_eject || enter_gap;
    assign ph_val  = enter_eject ? PULSE_LD : GAP_LD;
    assign wd_load = enter_eject || enter_motor;
    assign wd_val  = enter_eject ? SENSE_LD : MOTOR_LD;

    vend_timer #(.W(TMR_W)) u_phase_tmr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .expired_o  (ph_exp)
    );

    vend_timer #(.W(TMR_W)) u_wdog_tmr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (wd_load),
        .load_val_i (wd_val),
        .expired_o  (wd_exp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 3'd0;
            coin_dime_q  <= 1'b0;
            sensed_q     <= 1'b0;
            eject5_q     <= 1'b0;
            eject10_q    <= 1'b0;
            motor_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            nickel_cnt_q <= '0;
            dime_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inv_load) begin
                        nickel_cnt_q <= inv_nickels;
                        dime_cnt_q   <= inv_dimes;
                    end
                    if (start) begin
                        busy_q <= 1'b1;
                        if (change_units > MAX_CHANGE_UNITS) begin
                            state_q      <= ST_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_BAD_REQ;
                        end else if (change_units == 3'd0) begin
                            state_q <= ST_MOTOR;
                            motor_q <= 1'b1;
                        end else begin
                            remaining_q <= change_units;
                            state_q     <= ST_PICK;
                        end
                    end
                end
                ST_PICK: begin
                    sensed_q <= 1'b0;
                    if (remaining_q == 3'd0) begin
                        state_q <= ST_MOTOR;
                        motor_q <= 1'b1;
                    end else if (pick_dime) begin
                        state_q     <= ST_EJECT;
                        coin_dime_q <= 1'b1;
                        eject10_q   <= 1'b1;
                        dime_cnt_q  <= sat_dec(dime_cnt_q);
                    end else if (pick_nickel) begin
                        state_q      <= ST_EJECT;
                        coin_dime_q  <= 1'b0;
                        eject5_q     <= 1'b1;
                        nickel_cnt_q <= sat_dec(nickel_cnt_q);
                    end else begin
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_NO_CHANGE;
                    end
                end
                ST_EJECT: begin
                    // Only the first sensor pulse per coin is credited.
                    if (coin_sensed && !sensed_q) begin
                        sensed_q    <= 1'b1;
                        remaining_q <= remaining_q - coin_units(coin_dime_q);
                    end
                    if (ph_exp) begin
                        eject5_q  <= 1'b0;
                        eject10_q <= 1'b0;
                        state_q   <= (sensed_q || coin_sensed) ? ST_GAP : ST_WAIT_SENSE;
                    end
                end
                ST_WAIT_SENSE: begin
                    if (coin_sensed) begin
                        remaining_q <= remaining_q - coin_units(coin_dime_q);
                        state_q     <= ST_GAP;
                    end else if (wd_exp) begin
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_COIN_JAM;
                    end
                end
                ST_GAP: begin
                    if (ph_exp) begin
                        state_q <= ST_PICK;
                    end
                end
                ST_MOTOR: begin
                    if (item_sensed) begin
                        motor_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (wd_exp) begin
                        motor_q      <= 1'b0;
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_ITEM_JAM;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        fault_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        remaining_q <= 3'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign eject5     = eject5_q;
    assign eject10    = eject10_q;
    assign motor_on   = motor_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign nickel_cnt = nickel_cnt_q;
    assign dime_cnt   = dime_cnt_q;

endmodule

// File: tb/tb_vend_payout_sequencer.sv
// Directed bench for vend_payout_sequencer: cycle table plus multi-cycle payout scenarios.
module tb_vend_payout_sequencer;

    localparam int PULSE_CYC = 4;
    localparam int GAP_CYC   = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, coin_sensed, item_sensed, inv_load, clear_fault;
    logic [2:0] change_units;
    logic [7:0] inv_nickels, inv_dimes;
    logic       eject5, eject10, motor_on, busy, done, fault;
    logic [1:0] fault_code;
    logic [7:0] nickel_cnt, dime_cnt;

    int vectors = 0;
    int miscompares = 0;

    vend_payout_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .change_units (change_units),
        .coin_sensed  (coin_sensed),
        .item_sensed  (item_sensed),
        .inv_load     (inv_load),
        .inv_nickels  (inv_nickels),
        .inv_dimes    (inv_dimes),
        .clear_fault  (clear_fault),
        .eject5       (eject5),
        .eject10      (eject10),
        .motor_on     (motor_on),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .fault_code   (fault_code),
        .nickel_cnt   (nickel_cnt),
        .dime_cnt     (dime_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [2:0] chg;
        logic       coin;
        logic       item;
        logic       load;
        logic [7:0] ln;
        logic [7:0] ld;
        logic       clr;
        logic [23:0] exp_out;
    } vec_t;

    vec_t tbl[$];

    // Result of the last run_payout call
    int r_n5, r_n10, r_e_cyc, r_f_cyc, r_mot;
    bit r_pulse_ok, r_gap_ok, r_done, r_fault;

    function automatic logic [23:0] outv();
        return {eject5, eject10, motor_on, busy, done, fault, fault_code, nickel_cnt, dime_cnt};
    endfunction

    function automatic logic [23:0] ev(logic e5, logic e10, logic mot, logic bsy, logic dn,
                                       logic flt, logic [1:0] code, logic [7:0] nc, logic [7:0] dc);
        return {e5, e10, mot, bsy, dn, flt, code, nc, dc};
    endfunction

    task automatic add(logic st, logic [2:0] chg, logic coin, logic item, logic load,
                       logic [7:0] ln, logic [7:0] ld, logic clr, logic [23:0] e);
        vec_t v;
        v.start = st; v.chg = chg; v.coin = coin; v.item = item; v.load = load;
        v.ln = ln; v.ld = ld; v.clr = clr; v.exp_out = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; change_units = 0; coin_sensed = 0; item_sensed = 0;
        inv_load = 0; inv_nickels = 0; inv_dimes = 0; clear_fault = 0;
    endtask

    task automatic load_inv(input logic [7:0] n, input logic [7:0] d);
        inv_load = 1; inv_nickels = n; inv_dimes = d;
        tick();
        inv_load = 0;
    endtask

    task automatic do_clear();
        clear_fault = 1;
        tick();
        clear_fault = 0;
    endtask

    // Starts a payout and plays the coin/item sensors; stops on done, fault or cycle budget.
    task automatic run_payout(input logic [2:0] chg, input bit sense_en, input bit item_en,
                              input bit restart_en);
        int  hi_len, lo_len, mlen;
        bit  seen_pulse, prev_hi;
        r_n5 = 0; r_n10 = 0; r_e_cyc = -1; r_f_cyc = -1; r_mot = 0;
        r_pulse_ok = 1; r_gap_ok = 1; r_done = 0; r_fault = 0;
        hi_len = 0; lo_len = 0; mlen = 0; seen_pulse = 0; prev_hi = 0;
        start = 1; change_units = chg;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            coin_sensed = 0; item_sensed = 0; start = 0;
            if (eject5 || eject10) begin
                if (!prev_hi) begin
                    if (eject10) r_n10++; else r_n5++;
                    if (r_e_cyc < 0) r_e_cyc = cyc;
                    // GAP_CYC gap cycles plus the one-cycle coin selection
                    if (seen_pulse && lo_len != GAP_CYC + 1) r_gap_ok = 0;
                    hi_len = 0;
                end
                hi_len++;
                if (sense_en && hi_len == 2) coin_sensed = 1;
            end else begin
                if (prev_hi) begin
                    seen_pulse = 1;
                    lo_len = 0;
                    if (hi_len != PULSE_CYC) r_pulse_ok = 0;
                end
                lo_len++;
            end
            prev_hi = eject5 || eject10;
            if (motor_on) begin
                r_mot++;
                mlen++;
                if (item_en && mlen == 3) item_sensed = 1;
            end
            if (restart_en && cyc == 12) begin
                start = 1; change_units = 3'd4;
            end
            if (done) begin r_done = 1; break; end
            if (fault) begin r_fault = 1; r_f_cyc = cyc; break; end
            tick();
        end
        coin_sensed = 0; item_sensed = 0; start = 0; change_units = 0;
    endtask

    initial begin
        int extra;
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset", outv(), 24'h0);
        reset_n = 1;
        tick();
        chk("reset_state", outv(), 24'h0);

        // One row per clock: inputs applied, outputs checked after the edge.
        add(0,0,0,0,1,5,5,0, ev(0,0,0,0,0,0,2'b00,5,5));   // load 5/5
        add(1,6,0,0,0,0,0,0, ev(0,0,0,1,0,1,2'b00,5,5));   // change 6 -> bad request
        add(1,1,1,1,0,0,0,0, ev(0,0,0,1,0,1,2'b00,5,5));   // start/sensors ignored in fault
        add(0,0,0,0,0,0,0,1, ev(0,0,0,0,0,0,2'b00,5,5));   // clear_fault
        add(1,1,0,0,1,2,7,0, ev(0,0,0,1,0,0,2'b00,2,7));   // start + load same cycle -> PICK
        add(0,0,0,0,0,0,0,0, ev(1,0,0,1,0,0,2'b00,1,7));   // nickel eject, count dec
        add(0,0,1,0,0,0,0,0, ev(1,0,0,1,0,0,2'b00,1,7));   // coin sensed mid-pulse
        add(0,0,0,0,0,0,0,0, ev(1,0,0,1,0,0,2'b00,1,7));
        add(0,0,0,0,0,0,0,0, ev(1,0,0,1,0,0,2'b00,1,7));   // 4th pulse cycle
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));   // GAP
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));
        add(0,0,0,0,1,9,9,0, ev(0,0,0,1,0,0,2'b00,1,7));   // load ignored while busy
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));
        add(1,2,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));   // start ignored while busy
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));   // last GAP cycle
        add(0,0,0,0,0,0,0,0, ev(0,0,0,1,0,0,2'b00,1,7));   // PICK
        add(0,0,0,0,0,0,0,0, ev(0,0,1,1,0,0,2'b00,1,7));   // remaining 0 -> MOTOR
        add(0,0,0,1,0,0,0,0, ev(0,0,0,0,1,0,2'b00,1,7));   // item sensed -> done
        add(0,0,0,0,0,0,0,0, ev(0,0,0,0,0,0,2'b00,1,7));   // done is one cycle

        foreach (tbl[i]) begin
            start = tbl[i].start; change_units = tbl[i].chg; coin_sensed = tbl[i].coin;
            item_sensed = tbl[i].item; inv_load = tbl[i].load; inv_nickels = tbl[i].ln;
            inv_dimes = tbl[i].ld; clear_fault = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d", i), outv(), tbl[i].exp_out);
        end
        idle_inputs();

        // Two dimes for 20 cents
        load_inv(5, 5);
        run_payout(3'd4, 1, 1, 0);
        chk("A_dime_pulses", r_n10, 2);
        chk("A_nickel_pulses", r_n5, 0);
        chk("A_pulse_len", r_pulse_ok, 1);
        chk("A_gap_len", r_gap_ok, 1);
        chk("A_done", r_done, 1);
        chk("A_counts", {nickel_cnt, dime_cnt}, {8'd5, 8'd3});
        tick();
        chk("A_after_done", {busy, done}, 2'b00);

        // Only nickels available
        load_inv(5, 0);
        run_payout(3'd3, 1, 1, 0);
        chk("B_nickel_pulses", r_n5, 3);
        chk("B_dime_pulses", r_n10, 0);
        chk("B_pulse_len", r_pulse_ok, 1);
        chk("B_done", r_done, 1);
        chk("B_nickel_cnt", nickel_cnt, 2);
        tick();

        // One dime then no way to pay the last nickel
        load_inv(0, 1);
        run_payout(3'd3, 1, 1, 0);
        chk("C_dime_pulses", r_n10, 1);
        chk("C_fault", {r_fault, fault_code}, {1'b1, 2'b01});
        do_clear();
        chk("C_cleared", {busy, fault, fault_code, dime_cnt}, {1'b0, 1'b0, 2'b01, 8'd0});

        // Coin never sensed: coin jam 64 cycles after the eject starts
        load_inv(3, 0);
        run_payout(3'd1, 0, 1, 0);
        chk("D_pulse_len", r_pulse_ok, 1);
        chk("D_timeout_cycles", r_f_cyc - r_e_cyc, 64);
        chk("D_fault", {r_fault, fault_code, busy, eject5}, {1'b1, 2'b10, 1'b1, 1'b0});
        chk("D_nickel_cnt", nickel_cnt, 2);
        do_clear();

        // Item never sensed: motor held 256 cycles then item jam
        run_payout(3'd0, 1, 0, 0);
        chk("E_motor_cycles", r_mot, 256);
        chk("E_fault", {r_fault, fault_code, motor_on}, {1'b1, 2'b11, 1'b0});
        do_clear();
        chk("E_cleared", {busy, fault, fault_code}, {1'b0, 1'b0, 2'b11});

        // Second start while busy does not queue another payout
        load_inv(5, 5);
        run_payout(3'd2, 1, 1, 1);
        chk("G_dime_pulses", r_n10, 1);
        chk("G_done", r_done, 1);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (eject5 || eject10 || motor_on || busy) extra++;
        end
        chk("G_no_requeue", extra, 0);
        chk("G_counts", {nickel_cnt, dime_cnt}, {8'd5, 8'd4});

        // Asynchronous reset in the middle of an eject pulse
        load_inv(4, 4);
        start = 1; change_units = 3'd2;
        tick();
        start = 0;
        extra = 0;
        while (!eject10 && extra < 10) begin
            tick();
            extra++;
        end
        chk("F_eject_started", eject10, 1);
        tick();
        reset_n = 0;
        #1;
        chk("F_reset_immediate", outv(), 24'h0);
        tick();
        reset_n = 1;
        tick();
        chk("F_after_reset", outv(), 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
